// File: rtl/crc_pkg.sv
// Shared CRC definitions: FSM state encoding, supported width range and
// bit-reflection helpers used by the stream engine and its byte step.
package crc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } crc_state_t;

   localparam int CRC_WIDTH_MIN = 8;
   localparam int CRC_WIDTH_MAX = 32;

   function automatic logic [7:0] reflect8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   // Reverses the low w bits of v; bits at and above w come back as zero.
   function automatic logic [CRC_WIDTH_MAX-1:0] bit_reverse(input logic [CRC_WIDTH_MAX-1:0] v,
                                                            input int w);
      logic [CRC_WIDTH_MAX-1:0] r;
      r = '0;
      for (int i = 0; i < CRC_WIDTH_MAX; i++)
         if (i < w) r[i] = v[w-1-i];
      return r;
   endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational one-byte CRC update: eight serial shift/xor steps unrolled,
// MSB first, or LSB first when refin is set.
module crc_byte_step
   import crc_pkg::*;
#(
   parameter int CRC_WIDTH = 16
) (
   input  logic [CRC_WIDTH-1:0] crc,
   input  logic [CRC_WIDTH-1:0] poly,
   input  logic [7:0]           data,
   input  logic                 refin,
   output logic [CRC_WIDTH-1:0] crc_next
);

   logic [7:0]           d;
   logic [CRC_WIDTH-1:0] c;
   logic                 fb;

   always_comb begin
      d  = refin ? reflect8(data) : data;
      c  = crc;
      fb = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         fb = c[CRC_WIDTH-1] ^ d[i];
         c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? poly : '0);
      end
      crc_next = c;
   end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: per-message configuration latched at start, one byte
// per cycle, registered result held under a valid/ready handshake.
module crc_stream_engine
   import crc_pkg::*;
#(
   parameter int CRC_WIDTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 start_i,
   input  logic                 clear_i,
   input  logic [CRC_WIDTH-1:0] poly_i,
   input  logic [CRC_WIDTH-1:0] init_i,
   input  logic [CRC_WIDTH-1:0] xorout_i,
   input  logic                 refin_i,
   input  logic                 refout_i,
   input  logic [7:0]           data_i,
   input  logic                 valid_i,
   input  logic                 last_i,
   output logic                 ready_o,
   output logic [CRC_WIDTH-1:0] crc_o,
   output logic                 crc_valid_o,
   input  logic                 crc_ready_i,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] byte_cnt_o
);

   crc_state_t           state_q, state_d;
   logic [CRC_WIDTH-1:0] poly_q, xorout_q, crc_q;
   logic                 refin_q, refout_q;
   logic [CRC_WIDTH-1:0] crc_step, crc_rev, crc_fin;
   logic                 accept;

   crc_byte_step #(.CRC_WIDTH(CRC_WIDTH)) u_step (
      .crc      (crc_q),
      .poly     (poly_q),
      .data     (data_i),
      .refin    (refin_q),
      .crc_next (crc_step)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      ready_o     = 1'b0;
      crc_valid_o = 1'b0;
      busy_o      = 1'b1;
      accept      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy_o = 1'b0;
            if (start_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            ready_o = 1'b1;
            accept  = valid_i & ~clear_i;
            if (valid_i && last_i) state_d = ST_DONE;
         end
         ST_DONE: begin
            crc_valid_o = 1'b1;
            if (crc_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (clear_i) state_d = ST_IDLE;
   end

   // Result is formed from the post-update CRC so it is ready on DONE entry.
   always_comb begin
      crc_rev = '0;
      for (int i = 0; i < CRC_WIDTH; i++) crc_rev[i] = crc_step[CRC_WIDTH-1-i];
      crc_fin = (refout_q ? crc_rev : crc_step) ^ xorout_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         poly_q     <= '0;
         xorout_q   <= '0;
         refin_q    <= 1'b0;
         refout_q   <= 1'b0;
         crc_q      <= '0;
         crc_o      <= '0;
         byte_cnt_o <= '0;
      end else if (clear_i) begin
         crc_q <= '0;
      end else begin
         if (state_q == ST_IDLE && start_i) begin
            poly_q     <= poly_i;
            xorout_q   <= xorout_i;
            refin_q    <= refin_i;
            refout_q   <= refout_i;
            crc_q      <= init_i;
            byte_cnt_o <= '0;
         end
         if (accept) begin
            crc_q <= crc_step;
            if (byte_cnt_o != '1) byte_cnt_o <= byte_cnt_o + CNT_WIDTH'(1);
            if (last_i) crc_o <= crc_fin;
         end
      end
   end

endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 SHALL have parameter CRC_WIDTH, default 16: CRC register width; legal range 8..32.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the accepted-byte counter.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state SHALL update on the rising edge.
REQ-004 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start_i, input, 1: one-cycle request to begin a message.
REQ-006 SHALL have port clear_i, input, 1: synchronous abort back to IDLE.
REQ-007 SHALL have ports poly_i, init_i and xorout_i, input, CRC_WIDTH each: polynomial (implicit top bit omitted), seed and final XOR.
REQ-008 SHALL have ports refin_i and refout_i, input, 1 each: reflect input bytes; reflect the final CRC.
REQ-009 SHALL have ports data_i (input, 8), valid_i (input, 1), last_i (input, 1) and ready_o (output, 1): byte stream with valid/ready handshake.
REQ-010 SHALL have ports crc_o (output, CRC_WIDTH), crc_valid_o (output, 1) and crc_ready_i (input, 1): result with valid/ready handshake.
REQ-011 SHALL have ports busy_o (output, 1) and byte_cnt_o (output, CNT_WIDTH): engine not IDLE; bytes accepted in the current message.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE, start_i=1 SHALL latch poly/init/xorout/refin/refout into internal registers, load crc_q with init_i and byte_cnt with 0, and move to RUN on the next cycle.
REQ-014 Configuration inputs SHALL be ignored outside the start cycle; the latched values SHALL be used for the whole message.
REQ-015 ready_o SHALL be 1 only in RUN; a byte is accepted when valid_i and ready_o are both 1.
REQ-016 Each accepted byte SHALL update crc_q in the same cycle, giving a throughput of 1 byte per cycle.
REQ-017 Per-byte update SHALL process 8 bits, MSB first, or LSB first when refin=1. For each bit: fb = crc_q[CRC_WIDTH-1] XOR bit; crc_q = (crc_q << 1) XOR (fb ? poly : 0).
REQ-018 Each accepted byte SHALL increment byte_cnt, saturating at all-ones with no wrap.
REQ-019 An accepted byte with last_i=1 SHALL move the FSM to DONE.
REQ-020 On entry to DONE, crc_o SHALL register (refout ? bit-reverse(crc_q) : crc_q) XOR xorout.
REQ-021 crc_valid_o SHALL be 1 in the cycle after the last byte is accepted (1-cycle latency).
REQ-022 In DONE, crc_valid_o SHALL stay 1 and crc_o SHALL stay stable until crc_ready_i=1; the FSM then returns to IDLE on the next cycle.
REQ-023 start_i asserted in RUN or DONE SHALL be ignored.
REQ-024 A start_i in the same cycle as a DONE->IDLE handshake SHALL also be ignored; one IDLE cycle is mandatory.
REQ-025 clear_i=1 SHALL force IDLE on the next cycle from any state, discard crc_q, and deassert ready_o and crc_valid_o.
REQ-026 clear_i SHALL win over start_i when both are asserted.
REQ-027 valid_i while not in RUN SHALL have no effect.
REQ-028 crc_o, byte_cnt_o and the latched configuration SHALL hold their values in IDLE until the next start.
REQ-029 An empty message (start with no byte) SHALL NOT be possible; at least one byte with last_i=1 is required.

Reset
REQ-030 rst_n_i=0 SHALL asynchronously force: FSM=IDLE; crc_q, crc_o and byte_cnt_o = 0; ready_o, crc_valid_o and busy_o = 0; latched configuration = 0.
REQ-031 Reset asserted mid-message SHALL abandon the message with no output produced.
REQ-032 Release SHALL take effect on the first rising edge with rst_n_i=1.

Structure
REQ-033 A shared package crc_pkg SHALL hold the FSM state enum, CRC_WIDTH bounds, and reflect/bit-reverse functions.
REQ-034 One sub-module crc_byte_step SHALL be instantiated: combinational, parametrised on CRC_WIDTH; inputs crc, poly, data, refin; output next crc.
REQ-035 The fixed 16-bit step equations used elsewhere in the codebase SHALL be reproduced exactly by crc_byte_step when CRC_WIDTH=16 with poly 0x1021 or 0x8005, refin=0.

Verification
REQ-036 W=16, poly 0x1021, init 0xFFFF, xorout 0, refin=refout=0, bytes "123456789" back-to-back -> crc_o=0x29B1, byte_cnt_o=9, crc_valid_o 1 cycle after last.
REQ-037 W=16, poly 0x8005, init 0, refin=refout=1, "123456789" -> 0xBB3D; same message with refin=refout=0 -> 0xFEE8.
REQ-038 W=32, poly 0x04C11DB7, init and xorout 0xFFFFFFFF, refin=refout=1, "123456789" -> 0xCBF43926.
REQ-039 Stall and bubbles: valid_i toggled randomly and crc_ready_i held 0 for 5 cycles -> result 0x29B1 unchanged, crc_o stable while stalled, no byte lost or duplicated.
REQ-040 Aborts: clear_i pulsed after byte 4, and separately rst_n_i pulsed low mid-message -> IDLE next cycle with outputs per REQ-025/REQ-030; a fresh "123456789" message then gives 0x29B1.
REQ-041 Illegal timing: start_i asserted in RUN and DONE, and start_i and clear_i asserted together in IDLE -> no state change beyond REQ-023/REQ-026; byte_cnt saturation checked with CNT_WIDTH=4 and 20 bytes -> byte_cnt_o=0xF.
